// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings for the execute stage and its combinational core.
// Optional serial shifting is selected elsewhere with SERIAL_SHIFT_EN.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    function automatic logic is_shift_op(logic [ALU_OP_W-1:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result = f(op, a, b). With SERIAL_SHIFT_EN defined the shift
// ops only ever reach this block with a zero shift amount, so they pass A through.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o
);

`ifndef SERIAL_SHIFT_EN
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];
`endif

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves result_o
        // unassigned and infers a latch.
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
`ifdef SERIAL_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: result_o = a_i;
`else
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
`endif
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready input, one output register toward writeback.
// SERIAL_SHIFT_EN selects a one-bit-per-cycle shift FSM instead of the barrel shifter.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_alu_op,
    input  logic [XLEN-1:0]     in_op_a,
    input  logic [XLEN-1:0]     in_op_b,
    input  logic [TAG_W-1:0]    in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [TAG_W-1:0]    out_rd,
    output logic                out_zero,
    output logic                busy
);

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_rd_q, out_rd_d;
    logic             out_zero_q, out_zero_d;

    logic             accept;
    logic             start_serial;
    logic [XLEN-1:0]  core_result;

    alu_core #(.XLEN(XLEN)) u_core (
        .op_i     (in_alu_op),
        .a_i      (in_op_a),
        .b_i      (in_op_b),
        .result_o (core_result)
    );

    // A new op may enter in the same cycle the held result is drained.
    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef SERIAL_SHIFT_EN
    localparam int SHW = $clog2(XLEN);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic                state_q, state_d;
    logic [XLEN-1:0]     sh_val_q, sh_val_d;
    logic [XLEN-1:0]     sh_step;
    logic [ALU_OP_W-1:0] sh_op_q, sh_op_d;
    logic [TAG_W-1:0]    sh_rd_q, sh_rd_d;
    logic [SHW-1:0]      sh_cnt_q, sh_cnt_d;
    logic                shift_done;

    assign busy         = (state_q == ST_SHIFT);
    assign start_serial = accept && is_shift_op(in_alu_op) && (in_op_b[SHW-1:0] != '0);
    assign shift_done   = busy && (sh_cnt_q == SHW'(1));

    always_comb begin
        sh_step = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
        case (sh_op_q)
            ALU_SLL: sh_step = {sh_val_q[XLEN-2:0], 1'b0};
            ALU_SRL: sh_step = {1'b0, sh_val_q[XLEN-1:1]};
            default: sh_step = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sh_val_d = sh_val_q;
        sh_op_d  = sh_op_q;
        sh_rd_d  = sh_rd_q;
        sh_cnt_d = sh_cnt_q;
        if (start_serial) begin
            state_d  = ST_SHIFT;
            sh_val_d = in_op_a;
            sh_op_d  = in_alu_op;
            sh_rd_d  = in_rd;
            sh_cnt_d = in_op_b[SHW-1:0];
        end else if (busy) begin
            sh_val_d = sh_step;
            sh_cnt_d = sh_cnt_q - SHW'(1);
            if (shift_done) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the shift datapath is left unreset; it is only ever read while state_q says
    // SHIFT, and every entry into SHIFT loads it first.
    always_ff @(posedge clk) begin
        sh_val_q <= sh_val_d;
        sh_op_q  <= sh_op_d;
        sh_rd_q  <= sh_rd_d;
        sh_cnt_q <= sh_cnt_d;
    end
`else
    assign busy         = 1'b0;
    assign start_serial = 1'b0;
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_zero_d   = out_zero_q;
        if (accept && !start_serial) begin
            out_valid_d  = 1'b1;
            out_result_d = core_result;
            out_rd_d     = in_rd;
            out_zero_d   = (core_result == '0);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
`ifdef SERIAL_SHIFT_EN
        if (shift_done) begin
            out_valid_d  = 1'b1;
            out_result_d = sh_step;
            out_rd_d     = sh_rd_q;
            out_zero_d   = (sh_step == '0);
        end
`endif
    end

    // NOTE: non-blocking assignments for every register, so all state updates see the
    // values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_zero_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed cases then randomized ops against a
// behavioural model. Honours SERIAL_SHIFT_EN for expected shift latency and busy.
module tb_alu_exec_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_op;
    logic [XLEN-1:0]  in_op_a;
    logic [XLEN-1:0]  in_op_b;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;
    logic             out_zero;
    logic             busy;

    alu_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_op  (in_alu_op),
        .in_op_a    (in_op_a),
        .in_op_b    (in_op_b),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] rd;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_from = -1;
    int   busy_to = -2;
    bit   rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the opcode table, using plain arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        int unsigned sh;
        sh = b % XLEN;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return a[XLEN-1] ? ~((~a) >> sh) : (a >> sh);
            4'b0110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input logic [XLEN-1:0] b);
`ifdef SERIAL_SHIFT_EN
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b1101) && (b % XLEN) != 0)
            return int'(b % XLEN) + 1;
`endif
        return 1;
    endfunction

    // Called at the negedge where the handshake is seen; accept takes the next edge.
    task automatic record(input logic [3:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] rd);
        exp_t e;
        int   lat;
        lat   = latency(op, b);
        e.res = model(op, a, b);
        e.rd  = rd;
        e.due = cyc + lat;
        sb.push_back(e);
        if (lat > 1) begin
            busy_from = cyc + 1;
            busy_to   = cyc + lat - 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1 so consecutive calls drive back-to-back ops.
    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] rd,
                         output int waited);
        bit ok;
        ok        = 1'b0;
        waited    = 0;
        in_valid  = 1'b1;
        in_alu_op = op;
        in_op_a   = a;
        in_op_b   = b;
        in_rd     = rd;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            else waited++;
        end
        if (ok) record(op, a, b, rd);
        else check("accept_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops on each newly presented result, checks stability while stalled.
    initial begin
        logic             pv, pr, pz;
        logic [XLEN-1:0]  pres;
        logic [TAG_W-1:0] prd;
        exp_t             e;
        pv = 1'b0; pr = 1'b0; pz = 1'b0; pres = '0; prd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stable", {out_valid, out_zero, out_rd, out_result},
                          {1'b1, pz, prd, pres});
                end else if (out_valid) begin
                    check("output_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("result", 64'(out_result), 64'(e.res));
                        check("rd", 64'(out_rd), 64'(e.rd));
                        check("zero", 64'(out_zero), 64'(e.res == '0));
                        check("latency_cycle", 64'(cyc), 64'(e.due));
                    end
                end
                check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
                pv = out_valid; pr = out_ready; pz = out_zero; pres = out_result; prd = out_rd;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] valid_ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                   4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    logic [3:0] undef_ops [6]  = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
    logic [XLEN-1:0] corners [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int w0, w1;
        logic [3:0]      op;
        logic [XLEN-1:0] a, b;

        rst = 1'b1; in_valid = 1'b0; in_alu_op = '0; in_op_a = '0; in_op_b = '0;
        in_rd = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD overflow wraps into the sign bit.
        issue(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd3, w0);
        @(negedge clk);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_result", 64'(out_result), 64'h8000_0000);
        check("add_rd", 64'(out_rd), 64'd3);
        check("add_zero", 64'(out_zero), 64'd0);
        tick(1);

        // SUB then SLT back-to-back with the consumer always ready.
        issue(4'b1000, 32'd5, 32'd5, 5'd7, w0);
        issue(4'b0110, 32'hFFFF_FFFF, 32'h1, 5'd8, w1);
        check("b2b_first_wait", 64'(w0), 64'd0);
        check("b2b_second_wait", 64'(w1), 64'd0);
        tick(2);

        // Backpressure: held result blocks input until released, then same-cycle accept.
        out_ready = 1'b0;
        issue(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd9, w0);
        in_valid = 1'b1; in_alu_op = 4'b0010; in_op_a = 32'h1200_0000; in_op_b = 32'h0000_0034;
        in_rd = 5'd10;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) record(in_alu_op, in_op_a, in_op_b, in_rd);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain();

        // Shifts: arithmetic vs logical right, left with a shamt wider than log2(XLEN) bits.
        issue(4'b1101, 32'h8000_0000, 32'd4, 5'd11, w0);
        wait_drain();
        issue(4'b0101, 32'h8000_0000, 32'd4, 5'd12, w0);
        wait_drain();
        issue(4'b0100, 32'h1, 32'h25, 5'd13, w0);
        wait_drain();
        issue(4'b0100, 32'h1234, 32'h20, 5'd14, w0);
        wait_drain();

        // Reset right after accepting a long shift drops the operation.
        issue(4'b0101, 32'hFFFF_FFFF, 32'd20, 5'd15, w0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        busy_from = -1;
        busy_to   = -2;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(25);

        // Randomized traffic with random downstream backpressure.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) op = undef_ops[$urandom_range(5)];
            else op = valid_ops[$urandom_range(9)];
            a = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            b = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            issue(op, a, b, TAG_W'($urandom), w0);
            if ($urandom_range(4) == 0) tick($urandom_range(3));
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
